// File: rtl/softmax_pkg.sv
// Shared softmax types and helpers: Q4.12 constants, the {v,last} beat tag
// and the overflow-reporting (optionally saturating) Q4.12 add.
package softmax_pkg;

  localparam logic [15:0] FX_MAX = 16'h7FFF;
  localparam logic [15:0] FX_MIN = 16'h8000;
  localparam logic [15:0] FX_ONE = 16'h1000;

  typedef struct packed {
    logic v;
    logic last;
  } tag_t;

  typedef struct packed {
    logic        ovf;
    logic [15:0] sum;
  } fx_res_t;

  // Signed add; ovf flags two's-complement overflow, sat_en clamps the result
  function automatic fx_res_t fx_add(input logic [15:0] a, input logic [15:0] b,
                                     input logic sat_en);
    fx_res_t     r;
    logic [15:0] s;
    s     = a + b;
    r.ovf = (a[15] == b[15]) && (s[15] != a[15]);
    if (r.ovf && sat_en) begin
      r.sum = a[15] ? FX_MIN : FX_MAX;
    end else begin
      r.sum = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/sum_fifo2.sv
// Two-entry shifting result FIFO of {ovf,sum}; the head is always entry 0,
// so the head and its valid flag come straight from registers.
module sum_fifo2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [16:0] push_data_i,
  input  logic        pop_i,
  output logic [16:0] head_o,
  output logic        valid_o,
  output logic [1:0]  count_o
);

  logic [16:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic        pop_s;

  assign pop_s = pop_i & valid_q;

  // Next-state for entries and occupancy
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    case ({push_i, pop_s})
      2'b11: begin
        if (count_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = push_data_i;
        end else begin
          e0_d = push_data_i;
        end
      end
      2'b10: begin
        if (count_q == 2'd0) begin
          e0_d    = push_data_i;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          e1_d    = push_data_i;
          count_d = 2'd2;
        end else begin
          count_d = count_q;
        end
      end
      2'b01: begin
        e0_d    = e1_q;
        e1_d    = 17'd0;
        count_d = count_q - 2'd1;
      end
      default: begin
        count_d = count_q;
      end
    endcase
    valid_d = (count_d != 2'd0);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q    <= 17'd0;
      e1_q    <= 17'd0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign head_o  = e0_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/sum_tree_sched.sv
// Row scheduler/accumulator around the free-running softmax adder tree.
// Define SUM_TREE_SAT_EN to saturate the row accumulator instead of wrapping.
module sum_tree_sched
  import softmax_pkg::*;
#(
  parameter int N       = 64,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [N*16-1:0]   in_data,
  output logic              tree_en,
  output logic [N*16-1:0]   tree_in_1_flat,
  input  logic [15:0]       tree_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [15:0]       sum,
  output logic              ovf
);

  localparam int TREE_LAT = $clog2(N) * ADD_LAT;
`ifdef SUM_TREE_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  tag_t [TREE_LAT:0] tag_q;
  tag_t              tag_out_s;
  logic [N*16-1:0]   tree_in_d;
  logic [15:0]       acc_q, acc_d;
  logic              flag_q, flag_d;
  logic [1:0]        lasts_q, lasts_d;
  logic [1:0]        fifo_count_s;
  logic              fire_s, push_s;
  logic [16:0]       push_data_s, head_s;
  fx_res_t           add_s;

  assign fire_s    = in_valid & in_ready;
  assign in_ready  = ({1'b0, fifo_count_s} + {1'b0, lasts_q}) < 3'd2;
  assign tag_out_s = tag_q[TREE_LAT];
  assign tree_in_d = fire_s ? in_data : {(N*16){1'b0}};

  // Accumulate tree sums for tagged beats; a last tag closes the row
  always_comb begin
    acc_d       = acc_q;
    flag_d      = flag_q;
    push_s      = 1'b0;
    push_data_s = 17'd0;
    add_s       = fx_add(acc_q, tree_out, SAT_EN);
    if (tag_out_s.v) begin
      if (tag_out_s.last) begin
        push_s      = 1'b1;
        push_data_s = {flag_q | add_s.ovf, add_s.sum};
        acc_d       = 16'd0;
        flag_d      = 1'b0;
      end else begin
        acc_d  = add_s.sum;
        flag_d = flag_q | add_s.ovf;
      end
    end else begin
      acc_d  = acc_q;
      flag_d = flag_q;
    end
  end

  // Rows whose last beat is accepted but whose total is not yet in the FIFO
  always_comb begin
    case ({fire_s & in_last, push_s})
      2'b10:   lasts_d = lasts_q + 2'd1;
      2'b01:   lasts_d = lasts_q - 2'd1;
      default: lasts_d = lasts_q;
    endcase
  end

  // Tree drive, tag pipe, accumulator and credit registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_en        <= 1'b0;
      tree_in_1_flat <= {(N*16){1'b0}};
      tag_q          <= '0;
      acc_q          <= 16'd0;
      flag_q         <= 1'b0;
      lasts_q        <= 2'd0;
    end else begin
      tree_en        <= 1'b1;
      tree_in_1_flat <= tree_in_d;
      tag_q          <= {tag_q[TREE_LAT-1:0], tag_t'{v: fire_s, last: fire_s & in_last}};
      acc_q          <= acc_d;
      flag_q         <= flag_d;
      lasts_q        <= lasts_d;
    end
  end

  sum_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (sum_ready),
    .head_o      (head_s),
    .valid_o     (sum_valid),
    .count_o     (fifo_count_s)
  );

  assign sum = head_s[15:0];
  assign ovf = head_s[16];

endmodule

// File: doc/sum_tree_sched.md
# sum_tree_sched

Scheduler and accumulator that sequences the softmax denominator adder tree (`add_tree`) over rows longer than one tree width. It accepts a row as a stream of N-lane Q4.12 beats and keeps the tree's free-running pipeline continuously enabled. It tags each beat through the tree latency, accumulates the per-beat tree sums into a row total, and returns one 16-bit sum per row through a 2-entry result FIFO with valid/ready backpressure.

## Interface
- `N`, 64: lanes per beat; must equal the tree's `N`, power of two ≥ 2.
- `ADD_LAT`, 1: cycles of latency per `add_FX16` stage.
- `TREE_LAT`, `$clog2(N)*ADD_LAT`: derived (localparam), tree input-to-`out` latency.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  beat offered.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready` (fire).
- `in_last`  in  1  beat is the final beat of its row.
- `in_data`  in  N*16  N lanes, Q4.12 two's complement, lane i at `[i*16 +: 16]`.
- `tree_en`  out  1  drives tree `en`.
- `tree_in_1_flat`  out  N*16  drives tree `in_1_flat`.
- `tree_out`  in  16  from tree `out`.
- `sum_valid`  out  1  row total available.
- `sum_ready`  in  1  consumer takes total when `sum_valid && sum_ready`.
- `sum`  out  16  row total, Q4.12.
- `ovf`  out  1  overflow flag of the head FIFO entry.

## Operation
- `tree_en`: a register, 0 in reset, 1 from the first edge after reset release. It stays 1 even when idle, because the tree adders free-run.
- `tree_in_1_flat`: a register, loaded with `in_data` on fire and with all-zero otherwise. Idle cycles therefore inject zero sums.
- Tag pipe: a shift register of depth `TREE_LAT+1` carrying `{v, last}`. It advances every cycle and loads `{fire, in_last}`.
- When the tag pipe's output `v=1`:
  - `acc_next = acc + tree_out`;
  - the overflow is the signed-add overflow of that add, OR'd into a sticky row flag.
- When the output tag also has `last=1`:
  - `{acc_next, row_flag}` is pushed to the FIFO;
  - `acc` and `row_flag` clear to 0 in the same edge.
- When the output tag has `v=0`, `acc` and `row_flag` hold.
- Credit rule:
  - `lasts_inflight` counts accepted `in_last` beats not yet pushed;
  - `in_ready = (fifo_count + lasts_inflight) < 2`, combinational from registers only, never from `in_valid`/`in_last`.
  - This guarantees the FIFO never overflows. Non-last beats of a row are also blocked when credit is 0.
- Simultaneous push (tag last) and pop (`sum_ready`): both take effect and the count is unchanged. Simultaneous fire of an `in_last` beat and push: `lasts_inflight` is unchanged.
- Rows of any length ≥ 1 beat. Back-to-back rows are allowed at full rate while credit remains.

## Timing
- Reset values: `in_ready` 1, `tree_en` 0, `tree_in_1_flat` 0, `sum_valid` 0, `sum` 0, `ovf` 0. Tag pipe, `acc`, counters and FIFO are cleared.
- Beat fired in cycle t:
  - appears on `tree_in_1_flat` in t+1;
  - its tree sum is on `tree_out` in t+1+TREE_LAT, which is when the tag reaches the output;
  - it is accumulated at the end of t+1+TREE_LAT.
- If that beat is last: `sum_valid` rises in t+TREE_LAT+2. Throughput is 1 beat/cycle.
- `sum`/`ovf` are the FIFO head, registered. They are stable while `sum_valid && !sum_ready`.
- Reset mid-row or with results pending: all in-flight tags, partial sums and FIFO contents are discarded. No output pulse occurs after reset asserts.

## Configuration
- `SUM_TREE_SAT_EN` defined: on overflow, `acc_next` saturates to 0x7FFF (positive) or 0x8000 (negative). `ovf` still reports it.
- `SUM_TREE_SAT_EN` undefined: the accumulator wraps (mod 2^16). `ovf` still reports it.
- Tree-internal wrap is outside this block's scope.

## Structure
- Shared package `softmax_pkg`:
  - Q4.12 constants `FX_MAX=16'h7FFF`, `FX_MIN=16'h8000`, `FX_ONE=16'h1000`;
  - the `{v,last}` tag typedef;
  - the saturating-add function used here and by other accumulators.
- One sub-module: `sum_fifo2` (2-entry, 17-bit `{ovf,sum}`, count output).
- Tag pipe, credit counter and accumulator stay inline.

## Test plan
Bench parameters: N=4, ADD_LAT=1, so TREE_LAT=2. The tree is modelled behaviourally with the same latency.
- Reset release: `tree_en`=0 during reset and 1 from the first edge after. All other outputs are 0 and `in_ready`=1.
- Single-beat row, lanes 0x1000×4, fire at t: `sum_valid` in t+4 with `sum`=0x4000, `ovf`=0.
- Row of 3 beats, lanes {0x0800×4, 0x1000×4, 0xF000×4}: `sum`=0x2000.
- Two beats of 0x1000×4, consecutive fires: `ovf`=1 in both builds. `sum`=0x7FFF with `SUM_TREE_SAT_EN`, 0x8000 without.
- Backpressure: `sum_ready`=0, three single-beat rows offered. Only two are accepted and `in_ready` stays 0. On one pop, `in_ready` returns in the next cycle; results are delivered in order.
- Assert `rst` mid-row with one result in the FIFO: `sum_valid` drops immediately. A next row 0x1000×4 yields 0x4000, uncontaminated by the earlier partial sum.
